// File: rtl/cache_control_nway.sv
`default_nettype none
// ============================================================================
//  Module      : cache_control_nway
//  Description : N-way set-associative cache controller. Zero-wait hits in
//                IDLE; on a miss it latches a victim way, optionally writes
//                it back, refills the line and retries. Saturating hit/miss
//                performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_control_nway #(
  parameter int WAYS  = 4,
  parameter int CNT_W = 16,
  localparam int IW   = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             readwrite,
  input  logic [WAYS-1:0]  hit,
  input  logic [WAYS-1:0]  valid,
  input  logic [WAYS-1:0]  dirty,
  input  logic [IW-1:0]    plru_victim,
  input  logic             pmem_resp,
  input  logic             count_clear,
  output logic [WAYS-1:0]  data_writeline,
  output logic [WAYS-1:0]  tag_write,
  output logic [WAYS-1:0]  valid_write,
  output logic [WAYS-1:0]  dirty_write,
  output logic             valid_in,
  output logic             dirty_in,
  output logic             wb_sel,
  output logic             lru_update,
  output logic [IW-1:0]    lru_way,
  output logic [IW:0]      adrmux_sel,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             cpu_resp,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WRITE_BACK = 3'd1,
    S_STALL      = 3'd2,
    S_LOAD_LINE  = 3'd3,
    S_UPDATE     = 3'd4
  } state_t;

  localparam logic [WAYS-1:0] c_one_hot0 = {{(WAYS-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_next;
  logic [IW-1:0]    r_victim;
  logic             r_was_miss;
  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_miss_count;

  logic [IW-1:0]    w_hit_way;
  logic [IW-1:0]    w_free_way;
  logic             w_free_any;
  logic             w_hit_any;
  logic [IW-1:0]    w_miss_victim;
  logic             w_miss_wb;
  logic [WAYS-1:0]  w_hit_oh;
  logic [WAYS-1:0]  w_victim_oh;
  logic             w_idle_hit;
  logic             w_idle_miss;
  logic             w_hit_inc;
  logic             w_miss_inc;

  // Lowest-index hitting way and lowest-index invalid way (descending scan so
  // the last assignment is the lowest index).
  always_comb begin
    w_hit_way  = '0;
    w_free_way = '0;
    w_free_any = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        w_hit_way = IW'(i);
      end
      if (!valid[i]) begin
        w_free_way = IW'(i);
        w_free_any = 1'b1;
      end
    end
  end

  assign w_hit_any     = |hit;
  assign w_miss_victim = w_free_any ? w_free_way : plru_victim;
  assign w_miss_wb     = valid[w_miss_victim] & dirty[w_miss_victim];
  assign w_hit_oh      = c_one_hot0 << w_hit_way;
  assign w_victim_oh   = c_one_hot0 << r_victim;
  assign w_idle_hit    = (r_state == S_IDLE) && req && w_hit_any;
  assign w_idle_miss   = (r_state == S_IDLE) && req && !w_hit_any;
  assign w_hit_inc     = w_idle_hit && !r_was_miss;
  assign w_miss_inc    = (r_state == S_UPDATE);

  // State register, victim latch and the retry marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_victim   <= '0;
      r_was_miss <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_idle_miss) begin
        r_victim <= w_miss_victim;
      end
      if (r_state == S_UPDATE) begin
        r_was_miss <= 1'b1;
      end else if (w_idle_hit) begin
        r_was_miss <= 1'b0;
      end
    end
  end

  // Next state and all control outputs; outputs are forced idle during reset.
  always_comb begin
    w_state_next   = r_state;
    data_writeline = '0;
    tag_write      = '0;
    valid_write    = '0;
    dirty_write    = '0;
    valid_in       = 1'b0;
    dirty_in       = 1'b0;
    wb_sel         = 1'b0;
    lru_update     = 1'b0;
    lru_way        = '0;
    adrmux_sel     = '0;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    cpu_resp       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req && w_hit_any) begin
          cpu_resp   = rst_n;
          lru_update = rst_n;
          lru_way    = rst_n ? w_hit_way : '0;
          if (readwrite && rst_n) begin
            wb_sel         = 1'b1;
            dirty_in       = 1'b1;
            data_writeline = w_hit_oh;
            dirty_write    = w_hit_oh;
          end
        end else if (req) begin
          w_state_next = w_miss_wb ? S_WRITE_BACK : S_LOAD_LINE;
        end
      end
      S_WRITE_BACK: begin
        pmem_write = rst_n;
        adrmux_sel = rst_n ? ((IW+1)'(r_victim) + (IW+1)'(1)) : '0;
        if (pmem_resp) begin
          w_state_next = S_STALL;
        end
      end
      S_STALL: begin
        w_state_next = S_LOAD_LINE;
      end
      S_LOAD_LINE: begin
        pmem_read = rst_n;
        if (pmem_resp) begin
          w_state_next = S_UPDATE;
          if (rst_n) begin
            data_writeline = w_victim_oh;
            tag_write      = w_victim_oh;
            valid_write    = w_victim_oh;
            dirty_write    = w_victim_oh;
            valid_in       = 1'b1;
            lru_update     = 1'b1;
            lru_way        = r_victim;
          end
        end
      end
      S_UPDATE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Saturating hit counter; a clear in the same cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count <= '0;
    end else if (count_clear) begin
      r_hit_count <= '0;
    end else if (w_hit_inc && (r_hit_count != '1)) begin
      r_hit_count <= r_hit_count + CNT_W'(1);
    end
  end

  // Saturating miss counter, stepped once per completed refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_count <= '0;
    end else if (count_clear) begin
      r_miss_count <= '0;
    end else if (w_miss_inc && (r_miss_count != '1)) begin
      r_miss_count <= r_miss_count + CNT_W'(1);
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_cache_control_nway.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_control_nway
//  Description : Self-checking bench for cache_control_nway (WAYS=4, CNT_W=4):
//                IDLE hit vector table, directed miss/refill sequences and a
//                randomized run against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_control_nway;

  localparam int WAYS  = 4;
  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0, readwrite = 1'b0, pmem_resp = 1'b0, count_clear = 1'b0;
  logic [3:0] hit = '0, valid = '0, dirty = '0;
  logic [1:0] plru_victim = '0;

  logic [3:0] data_writeline, tag_write, valid_write, dirty_write;
  logic       valid_in, dirty_in, wb_sel, lru_update, pmem_read, pmem_write, cpu_resp;
  logic [1:0] lru_way;
  logic [2:0] adrmux_sel;
  logic [3:0] hit_count, miss_count;

  typedef struct packed {
    logic       cpu_resp;
    logic       lru_update;
    logic [1:0] lru_way;
    logic [3:0] dwl;
    logic [3:0] tw;
    logic [3:0] vw;
    logic [3:0] dw;
    logic       valid_in;
    logic       dirty_in;
    logic       wb_sel;
    logic [2:0] adr;
    logic       pmem_read;
    logic       pmem_write;
  } out_t;

  out_t dut_o;
  assign dut_o = {cpu_resp, lru_update, lru_way, data_writeline, tag_write, valid_write,
                  dirty_write, valid_in, dirty_in, wb_sel, adrmux_sel, pmem_read, pmem_write};

  cache_control_nway #(.WAYS(WAYS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .readwrite(readwrite),
    .hit(hit), .valid(valid), .dirty(dirty), .plru_victim(plru_victim),
    .pmem_resp(pmem_resp), .count_clear(count_clear),
    .data_writeline(data_writeline), .tag_write(tag_write), .valid_write(valid_write),
    .dirty_write(dirty_write), .valid_in(valid_in), .dirty_in(dirty_in), .wb_sel(wb_sel),
    .lru_update(lru_update), .lru_way(lru_way), .adrmux_sel(adrmux_sel),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .cpu_resp(cpu_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rq, input logic rw, input logic [3:0] h, input logic [3:0] v,
                       input logic [3:0] d, input logic [1:0] pl, input logic rsp, input logic clr);
    req = rq; readwrite = rw; hit = h; valid = v; dirty = d;
    plru_victim = pl; pmem_resp = rsp; count_clear = clr;
  endtask

  task automatic do_reset();
    drive(0, 0, 4'h0, 4'h0, 4'h0, 2'd0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int P_IDLE = 0, P_WB = 1, P_STALL = 2, P_LOAD = 3, P_UPD = 4;
  int         m_phase;
  logic [1:0] m_victim;
  bit         m_was_miss;
  int         m_hc, m_mc;

  function automatic out_t model_out();
    out_t       o;
    logic [3:0] lb, voh;
    o   = '0;
    lb  = hit & (~hit + 4'd1);
    voh = 4'b0001 << m_victim;
    if (!rst_n) return o;
    case (m_phase)
      P_IDLE: if (req && hit != 4'h0) begin
        o.cpu_resp = 1; o.lru_update = 1; o.lru_way = 2'($clog2(lb));
        if (readwrite) begin o.wb_sel = 1; o.dirty_in = 1; o.dwl = lb; o.dw = lb; end
      end
      P_WB: begin o.pmem_write = 1; o.adr = 3'(m_victim) + 3'd1; end
      P_LOAD: begin
        o.pmem_read = 1;
        if (pmem_resp) begin
          o.dwl = voh; o.tw = voh; o.vw = voh; o.dw = voh;
          o.valid_in = 1; o.lru_update = 1; o.lru_way = m_victim;
        end
      end
      default: ;
    endcase
    return o;
  endfunction

  task automatic model_step();
    logic [3:0] inv, lb;
    case (m_phase)
      P_IDLE: if (req && hit != 4'h0) begin
        if (!m_was_miss) m_hc = (m_hc == 15) ? 15 : m_hc + 1;
        m_was_miss = 0;
      end else if (req) begin
        inv = ~valid;
        lb  = inv & (~inv + 4'd1);
        m_victim = (valid != 4'hF) ? 2'($clog2(lb)) : plru_victim;
        m_phase  = (valid[m_victim] && dirty[m_victim]) ? P_WB : P_LOAD;
      end
      P_WB:    if (pmem_resp) m_phase = P_STALL;
      P_STALL: m_phase = P_LOAD;
      P_LOAD:  if (pmem_resp) m_phase = P_UPD;
      default: begin
        m_mc = (m_mc == 15) ? 15 : m_mc + 1;
        m_was_miss = 1;
        m_phase = P_IDLE;
      end
    endcase
    if (count_clear) begin m_hc = 0; m_mc = 0; end
  endtask

  // ---------------- vector table for IDLE hits ----------------
  typedef struct {
    logic       rq;
    logic       rw;
    logic [3:0] h;
    out_t       exp;
    logic [3:0] hc;
  } vec_t;

  function automatic vec_t mk(logic rq, logic rw, logic [3:0] h, logic resp,
                              logic [1:0] way, logic [3:0] wr_oh, logic [3:0] hc);
    vec_t v;
    v.rq = rq; v.rw = rw; v.h = h; v.hc = hc;
    v.exp = '0;
    v.exp.cpu_resp = resp; v.exp.lru_update = resp; v.exp.lru_way = way;
    v.exp.dwl = wr_oh; v.exp.dw = wr_oh;
    v.exp.wb_sel = (wr_oh != 0); v.exp.dirty_in = (wr_oh != 0);
    return v;
  endfunction

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(1, 0, 4'b0100, 1, 2'd2, 4'b0000, 4'd1);
    vecs[1] = mk(1, 0, 4'b0110, 1, 2'd1, 4'b0000, 4'd2);
    vecs[2] = mk(1, 1, 4'b1000, 1, 2'd3, 4'b1000, 4'd3);
    vecs[3] = mk(0, 1, 4'b1111, 0, 2'd0, 4'b0000, 4'd3);
    vecs[4] = mk(1, 1, 4'b0011, 1, 2'd0, 4'b0001, 4'd4);
    vecs[5] = mk(1, 0, 4'b1111, 1, 2'd0, 4'b0000, 4'd5);
    vecs[6] = mk(1, 0, 4'b1010, 1, 2'd1, 4'b0000, 4'd6);

    // Reset state
    do_reset();
    @(negedge clk);
    chk("reset_outputs", 32'(dut_o), 32'h0);
    chk("reset_hit_count", 32'(hit_count), 32'h0);
    chk("reset_miss_count", 32'(miss_count), 32'h0);
    tick();

    // Table of IDLE accesses
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].rq, vecs[i].rw, vecs[i].h, 4'hF, 4'h0, 2'd0, 0, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_out", i), 32'(dut_o), 32'(vecs[i].exp));
      tick();
      chk($sformatf("vec%0d_hit_count", i), 32'(hit_count), 32'(vecs[i].hc));
    end

    // Read miss into an invalid way, no write-back
    do_reset();
    drive(1, 0, 4'h0, 4'b1011, 4'b1111, 2'd0, 0, 0);
    @(negedge clk); chk("rmiss_idle_resp", 32'(cpu_resp), 32'h0);
    tick();
    drive(1, 0, 4'h0, 4'b1011, 4'b1111, 2'd0, 0, 0);
    @(negedge clk);
    chk("rmiss_no_wb", 32'(pmem_write), 32'h0);
    chk("rmiss_load_read", 32'(pmem_read), 32'h1);
    chk("rmiss_load_tag_wait", 32'(tag_write), 32'h0);
    tick();
    pmem_resp = 1;
    @(negedge clk);
    chk("rmiss_load_tag", 32'(tag_write), 32'b0100);
    chk("rmiss_valid_in", 32'(valid_in), 32'h1);
    chk("rmiss_lru_way", 32'({lru_update, lru_way}), 32'b110);
    tick();
    pmem_resp = 0;
    @(negedge clk); chk("rmiss_update_quiet", 32'(dut_o), 32'h0);
    tick();
    chk("rmiss_miss_count", 32'(miss_count), 32'h1);
    drive(1, 0, 4'b0100, 4'hF, 4'hF, 2'd0, 0, 0);
    @(negedge clk); chk("rmiss_retry_resp", 32'(cpu_resp), 32'h1);
    tick();
    chk("rmiss_retry_no_hitcount", 32'(hit_count), 32'h0);
    drive(1, 0, 4'b0100, 4'hF, 4'hF, 2'd0, 0, 0);
    tick();
    chk("rmiss_next_hit_counts", 32'(hit_count), 32'h1);

    // Write miss with dirty victim from pseudo-LRU
    do_reset();
    drive(1, 1, 4'h0, 4'hF, 4'b1000, 2'd3, 0, 0);
    tick();
    drive(1, 1, 4'h0, 4'hF, 4'b1000, 2'd0, 0, 0);
    @(negedge clk);
    chk("wmiss_wb_write", 32'(pmem_write), 32'h1);
    chk("wmiss_wb_adr", 32'(adrmux_sel), 32'h4);
    tick();
    chk("wmiss_wb_hold", 32'(pmem_write), 32'h1);
    pmem_resp = 1;
    tick();
    @(negedge clk); chk("wmiss_stall_quiet", 32'(dut_o), 32'h0);
    tick();
    pmem_resp = 0;
    @(negedge clk);
    chk("wmiss_load_read", 32'({pmem_read, adrmux_sel}), 32'b1000);
    pmem_resp = 1;
    #1 chk("wmiss_load_vw", 32'(valid_write), 32'b1000);
    tick();
    pmem_resp = 0;
    tick();
    drive(1, 1, 4'b1000, 4'hF, 4'h0, 2'd0, 0, 0);
    @(negedge clk);
    chk("wmiss_retry_write", 32'({dirty_write, data_writeline, dirty_in, wb_sel}), 32'b1000_1000_1_1);

    // Multi-hit priority and latched victim across plru changes
    do_reset();
    drive(1, 0, 4'b0110, 4'hF, 4'h0, 2'd0, 0, 0);
    @(negedge clk); chk("multi_hit_way", 32'(lru_way), 32'h1);
    tick();
    drive(1, 0, 4'h0, 4'hF, 4'h0, 2'd1, 0, 0);
    tick();
    drive(1, 0, 4'hF, 4'h0, 4'hF, 2'd3, 0, 0);
    tick();
    pmem_resp = 1;
    @(negedge clk);
    chk("latched_victim_tag", 32'(tag_write), 32'b0010);
    chk("latched_victim_lru", 32'(lru_way), 32'h1);
    tick();

    // Counter saturation and clear priority
    do_reset();
    drive(1, 0, 4'b0001, 4'hF, 4'h0, 2'd0, 0, 0);
    repeat (15) tick();
    chk("hit_count_max", 32'(hit_count), 32'hF);
    tick();
    chk("hit_count_saturate", 32'(hit_count), 32'hF);
    count_clear = 1;
    tick();
    chk("hit_count_clear_wins", 32'(hit_count), 32'h0);
    count_clear = 0;

    // Asynchronous reset in WRITE_BACK
    do_reset();
    drive(1, 0, 4'b0010, 4'hF, 4'h0, 2'd0, 0, 0);
    tick();
    drive(1, 1, 4'h0, 4'hF, 4'b0100, 2'd2, 0, 0);
    tick();
    @(negedge clk); chk("arst_wb_active", 32'(pmem_write), 32'h1);
    #1 rst_n = 0;
    #1;
    chk("arst_outputs_off", 32'(dut_o), 32'h0);
    chk("arst_hit_count", 32'(hit_count), 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    drive(1, 0, 4'h0, 4'b0111, 4'hF, 2'd0, 0, 0);
    tick();
    @(negedge clk); chk("arst_new_miss_load", 32'({pmem_read, pmem_write}), 32'b10);
    pmem_resp = 1;
    #1 chk("arst_new_miss_tag", 32'(tag_write), 32'b1000);
    tick();

    // Randomized run against the reference model
    do_reset();
    m_phase = P_IDLE; m_victim = 0; m_was_miss = 0; m_hc = 0; m_mc = 0;
    for (int c = 0; c < 3000; c++) begin
      req         = ($urandom_range(0, 9) < 8);
      readwrite   = $urandom_range(0, 1);
      hit         = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      valid       = $urandom_range(0, 2) != 0 ? 4'hF : 4'($urandom);
      dirty       = 4'($urandom);
      plru_victim = 2'($urandom);
      pmem_resp   = ($urandom_range(0, 9) < 3);
      count_clear = ($urandom_range(0, 99) < 2);
      @(negedge clk);
      chk("rand_outputs", 32'(dut_o), 32'(model_out()));
      chk("rand_counters", 32'({hit_count, miss_count}), 32'({4'(m_hc), 4'(m_mc)}));
      model_step();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_control_nway.md
CACHE_CONTROL_NWAY -- requirements
Module: cache_control_nway

Interface
REQ-001 Parameter WAYS, default 4: associativity, power of two, 2..8; IW = log2(WAYS).
REQ-002 Parameter CNT_W, default 16: width of the hit and miss counters.
REQ-003 One clock; reset is asynchronous and active-low. Port list follows (name, direction, width, meaning).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req  in  1  CPU request valid; held until cpu_resp.
REQ-007 readwrite  in  1  0 = read, 1 = write.
REQ-008 hit, valid, dirty  in  WAYS each  per-way tag match, valid bit and dirty bit for the addressed set.
REQ-009 plru_victim  in  IW  victim way from the external pseudo-LRU array.
REQ-010 pmem_resp  in  1  physical memory done.
REQ-011 count_clear  in  1  synchronous clear of both counters.
REQ-012 data_writeline, tag_write, valid_write, dirty_write  out  WAYS each  one-hot per-way write enables.
REQ-013 valid_in, dirty_in, wb_sel  out  1 each  valid data, dirty data, data-in mux (1 = CPU write merge, 0 = memory line).
REQ-014 lru_update  out  1  touch way lru_way in the pseudo-LRU array; lru_way  out  IW.
REQ-015 adrmux_sel  out  IW+1  0 = CPU address; k+1 = tag of way k (write-back address).
REQ-016 pmem_read, pmem_write, cpu_resp  out  1 each.
REQ-017 hit_count, miss_count  out  CNT_W each  performance counters.

Function
REQ-018 States: IDLE, WRITE_BACK, STALL, LOAD_LINE, UPDATE; all outputs other than the counters are combinational from the state and the inputs.
REQ-019 Hit way = lowest-index set bit of hit; a hit exists when hit is nonzero. If more than one bit is set, the lowest index wins.
REQ-020 IDLE, req=1, hit: cpu_resp=1, lru_update=1, lru_way=hit way, and the block stays in IDLE (zero-wait hit).
REQ-021 IDLE write hit: additionally wb_sel=1, dirty_in=1, data_writeline and dirty_write one-hot on the hit way.
REQ-022 IDLE, req=1, miss: the victim way is latched as the lowest-index way with valid=0; if every way is valid, the victim is plru_victim.
REQ-023 On a miss, the next state is WRITE_BACK when the victim is valid and dirty; otherwise it is LOAD_LINE.
REQ-024 WRITE_BACK: pmem_write=1 and adrmux_sel=victim+1; the FSM moves to STALL on pmem_resp, otherwise it stays in WRITE_BACK.
REQ-025 STALL: all outputs are inactive for exactly one cycle, then the FSM moves to LOAD_LINE.
REQ-026 LOAD_LINE: pmem_read=1 and adrmux_sel=0. When pmem_resp=1, in the same cycle: data_writeline, tag_write, valid_write and dirty_write are one-hot on the victim; valid_in=1; dirty_in=0; wb_sel=0; lru_update=1 with lru_way=victim. The next state is then UPDATE.
REQ-027 UPDATE: miss_count increments and a was_miss flag is set; the next state is IDLE, and the retried access hits.
REQ-028 A hit in IDLE increments hit_count only when was_miss=0. Any hit clears was_miss.
REQ-029 Counters saturate at 2^CNT_W-1. When count_clear and an increment occur in the same cycle, the clear wins.
REQ-030 pmem_resp is ignored in IDLE, STALL and UPDATE.
REQ-031 req=0 in IDLE produces no outputs and no state change.
REQ-032 The victim register holds its value from the miss cycle until the next miss; changes on hit, valid, dirty or plru_victim in the meantime have no effect.

Reset
REQ-033 While rst_n=0: state=IDLE, victim=0, was_miss=0, hit_count=0, miss_count=0. All outputs are inactive immediately, including mid-transaction with pmem_read or pmem_write deasserting asynchronously.
REQ-034 The first rising edge with rst_n=1 evaluates IDLE normally.

Verification
REQ-035 WAYS=4: read, hit=0100 -> same cycle cpu_resp=1, lru_way=2, lru_update=1; hit_count 0->1.
REQ-036 Read miss, valid=1011, dirty=1111 -> victim=2, no WRITE_BACK. LOAD_LINE pmem_read held until pmem_resp; at pmem_resp tag_write=0100 and valid_in=1. UPDATE then gives miss_count=1. The retried hit does not increment hit_count.
REQ-037 Write miss, valid=1111, dirty=1000, plru_victim=3 -> WRITE_BACK with adrmux_sel=4, then STALL for 1 cycle, then LOAD_LINE. The retried write gives dirty_write=1000, dirty_in=1, wb_sel=1.
REQ-038 hit=0110 -> hit way 1 is selected. Also, with plru_victim changed mid-refill, the latched victim is still used.
REQ-039 Counter preset to 2^CNT_W-1 with a further hit -> value holds. count_clear together with a hit -> counter reads 0.
REQ-040 rst_n=0 asserted in WRITE_BACK -> pmem_write=0 in the same cycle. After release: IDLE, counters 0, and a new miss proceeds normally.
